sine_phase_sequencer: RTL
=========================

Name: sine_phase_sequencer

Overview:
- Controller for the sine_wave generator.
- Steps through a programmable table of phase offsets and holds each phase for a programmed number of output samples (dwell).
- Drives the generator's signed phase input and emits a one-cycle strobe on every step load.
- Sits between the configuration interface and sine_wave, so phase-hopping and PSK-style test patterns run without software timing.

Parameters:
PHASE_SIZE, 8, phase ports are PHASE_SIZE+1 bits signed, in degrees, legal range -180..180
NUM_STEPS, 8, depth of the step table (power of 2, >=2)
DWELL_WIDTH, 16, width of the per-step dwell count, in samples (one sample per clock)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
cfg_valid  in  1  table write request
cfg_ready  out  1  table write accepted when high together with cfg_valid
cfg_addr  in  $clog2(NUM_STEPS)  step index to write
cfg_phase  in  PHASE_SIZE+1 signed  step phase in degrees
cfg_dwell  in  DWELL_WIDTH  step hold length in samples
num_steps  in  $clog2(NUM_STEPS)+1  active step count, sampled on start
start  in  1  begin sequence (pulse)
stop  in  1  abort sequence (pulse)
loop_en  in  1  wrap to step 0 after the last step; sampled live
phase  out  PHASE_SIZE+1 signed  phase to sine_wave
phase_strobe  out  1  one-cycle pulse when a new step is loaded
step_idx  out  $clog2(NUM_STEPS)  current step
busy  out  1  sequence active
done  out  1  one-cycle pulse on natural completion

Behaviour:
- Reset (synchronous, active-high):
  - Outputs: phase=0, phase_strobe=0, step_idx=0, busy=0, done=0, cfg_ready=1.
  - Every table entry is set to phase=0, dwell=1.
  - State goes to IDLE.
  - Reset asserted mid-sequence aborts immediately with the same values; no done pulse.
- Table write:
  - cfg_ready=1 only in IDLE.
  - A write occurs on cfg_valid&&cfg_ready and is visible from the next cycle.
  - cfg_phase outside -180..180 is clamped to the nearest bound on write.
  - cfg_dwell=0 is stored as 1.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 and stop=0: latch N=num_steps, with 0 or >NUM_STEPS saturated to NUM_STEPS. Load step 0 and go to RUN.
  - start and stop together: stop wins, stay in IDLE.
- Step load (entering RUN or advancing):
  - Registers phase<=table[k].phase, step_idx<=k, phase_strobe<=1, dwell counter<=table[k].dwell-1.
  - Latency: phase and phase_strobe change on the clock edge after start is sampled.
- RUN:
  - busy=1.
  - Counter != 0: decrement.
  - Counter==0 and step_idx<N-1: load step_idx+1.
  - Counter==0 and step_idx==N-1 and loop_en=1: load step 0.
  - Counter==0 and step_idx==N-1 and loop_en=0: go to DONE.
  - Each step therefore holds phase for exactly dwell cycles; the first cycle carries the strobe.
- DONE: done=1 for one cycle, busy=0, then IDLE. phase holds the last step's value.
- stop in RUN: IDLE on the next edge, busy=0, no done pulse, phase holds its value, step_idx unchanged.
- start in RUN or DONE is ignored.
- Consecutive equal phases still strobe. Downstream uses phase_strobe, not phase change alone, to restart the generator.
- N=1 with loop_en=1: step 0 reloads every dwell cycles and strobes each time.
- Dwell counter width is DWELL_WIDTH. No arithmetic overflow is possible because loads are pre-decremented from values >=1.
- phase_strobe is combinationally independent of inputs; all outputs are registered.

Decomposition:
- Package sine_pkg:
  - Constants PHASE_SIZE, PHASE_MIN=-180, PHASE_MAX=180.
  - typedef phase_t (signed PHASE_SIZE+1).
  - typedef step_t struct {phase_t phase; logic [DWELL_WIDTH-1:0] dwell}.
  - Enum seq_state_t {IDLE, RUN, DONE}.
- Sub-module sine_step_table:
  - Register array of step_t with synchronous reset.
  - Write port with clamp and dwell fix-up.
  - Asynchronous read by index.
- Sequencer FSM, counter and output registers live in sine_phase_sequencer.

Test Plan:
- Reset, then program steps 0..2 = (0,4),(90,2),(-90,3); num_steps=3, loop_en=0; start at cycle t.
  -> phase=0 over t+1..t+4, 90 over t+5..t+6, -90 over t+7..t+9.
  -> phase_strobe at t+1, t+5, t+7; done at t+10; busy low from t+10.
- Same program with loop_en=1.
  -> step 0 reloads at t+10 with a strobe; deassert loop_en and the sequence ends after step 2 of the current pass.
- Writes with cfg_phase=200, cfg_phase=-250, cfg_dwell=0; single-step run.
  -> stored values read back via the run as phase=180, phase=-180, 1-cycle hold.
- stop two cycles into step 1.
  -> busy=0 on the next edge, no done, phase stays 90.
  -> cfg_ready returns 1; start with stop in the same cycle stays IDLE.
- Two consecutive steps of 45 with dwell 1.
  -> phase_strobe high on two consecutive cycles; start pulsed during RUN has no effect.
- Assert reset mid-RUN.
  -> next edge: all outputs at reset values, table cleared; a subsequent start plays phase 0 for 1 cycle per step.

Source files
------------

// File: rtl/sine_pkg.sv
// Shared types and constants for the sine_wave phase sequencer.
package sine_pkg;

  localparam int PHASE_SIZE  = 8;
  localparam int DWELL_WIDTH = 16;
  localparam int PHASE_MIN   = -180;
  localparam int PHASE_MAX   = 180;

  typedef logic signed [PHASE_SIZE:0] phase_t;

  typedef struct packed {
    phase_t                 phase;
    logic [DWELL_WIDTH-1:0] dwell;
  } step_t;

  typedef enum logic [1:0] {IDLE, RUN, DONE} seq_state_t;

  function automatic phase_t clamp_phase(phase_t p);
    if (p > phase_t'(PHASE_MAX)) begin
      return phase_t'(PHASE_MAX);
    end else if (p < phase_t'(PHASE_MIN)) begin
      return phase_t'(PHASE_MIN);
    end
    return p;
  endfunction

  // A zero dwell would underflow the pre-decremented counter, so it is promoted to one sample.
  function automatic logic [DWELL_WIDTH-1:0] fix_dwell(logic [DWELL_WIDTH-1:0] d);
    return (d == '0) ? DWELL_WIDTH'(1) : d;
  endfunction

endpackage

// File: rtl/sine_step_table.sv
// Step table: register array of (phase, dwell) with sanitising write port and async read.
module sine_step_table
  import sine_pkg::*;
#(
  parameter int unsigned NUM_STEPS = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         wr_en,
  input  logic [$clog2(NUM_STEPS)-1:0] wr_addr,
  input  phase_t                       wr_phase,
  input  logic [DWELL_WIDTH-1:0]       wr_dwell,
  input  logic [$clog2(NUM_STEPS)-1:0] rd_addr,
  output step_t                        rd_step
);

  step_t steps_q [NUM_STEPS];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_STEPS); i++) begin
        steps_q[i] <= '{phase: '0, dwell: DWELL_WIDTH'(1)};
      end
    end else if (wr_en) begin
      steps_q[wr_addr] <= '{phase: clamp_phase(wr_phase), dwell: fix_dwell(wr_dwell)};
    end
  end

  assign rd_step = steps_q[rd_addr];

endmodule

// File: rtl/sine_phase_sequencer.sv
// Steps sine_wave through a programmed table of phases, holding each for its dwell count.
module sine_phase_sequencer
  import sine_pkg::*;
#(
  parameter int unsigned NUM_STEPS = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         cfg_valid,
  output logic                         cfg_ready,
  input  logic [$clog2(NUM_STEPS)-1:0] cfg_addr,
  input  phase_t                       cfg_phase,
  input  logic [DWELL_WIDTH-1:0]       cfg_dwell,
  input  logic [$clog2(NUM_STEPS):0]   num_steps,
  input  logic                         start,
  input  logic                         stop,
  input  logic                         loop_en,
  output phase_t                       phase,
  output logic                         phase_strobe,
  output logic [$clog2(NUM_STEPS)-1:0] step_idx,
  output logic                         busy,
  output logic                         done
);

  localparam int IW = $clog2(NUM_STEPS);
  localparam int NW = IW + 1;

  seq_state_t             state_q, state_d;
  phase_t                 phase_q, phase_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [DWELL_WIDTH-1:0] cnt_q, cnt_d;
  logic [NW-1:0]          n_q, n_d;
  logic                   strobe_q, busy_q, done_q, cfg_ready_q;

  logic                   load;
  logic [IW-1:0]          load_idx;
  logic                   last_step;
  step_t                  rd_step;

  sine_step_table #(
    .NUM_STEPS(NUM_STEPS)
  ) u_table (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (cfg_valid && cfg_ready_q),
    .wr_addr (cfg_addr),
    .wr_phase(cfg_phase),
    .wr_dwell(cfg_dwell),
    .rd_addr (load_idx),
    .rd_step (rd_step)
  );

  assign last_step = ({1'b0, idx_q} == (n_q - NW'(1)));

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    n_d      = n_q;
    load     = 1'b0;
    load_idx = idx_q;

    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          n_d = ((num_steps == '0) || (num_steps > NW'(NUM_STEPS))) ? NW'(NUM_STEPS) : num_steps;
          load     = 1'b1;
          load_idx = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - DWELL_WIDTH'(1);
        end else if (!last_step) begin
          load     = 1'b1;
          load_idx = idx_q + IW'(1);
        end else if (loop_en) begin
          load     = 1'b1;
          load_idx = '0;
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Dwell is stored as >= 1, so the pre-decrement never wraps.
    if (load) begin
      phase_d = rd_step.phase;
      idx_d   = load_idx;
      cnt_d   = rd_step.dwell - DWELL_WIDTH'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      phase_q     <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      n_q         <= NW'(NUM_STEPS);
      strobe_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cfg_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      n_q         <= n_d;
      strobe_q    <= load;
      busy_q      <= (state_d == RUN);
      done_q      <= (state_d == DONE);
      cfg_ready_q <= (state_d == IDLE);
    end
  end

  assign phase        = phase_q;
  assign phase_strobe = strobe_q;
  assign step_idx     = idx_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign cfg_ready    = cfg_ready_q;

endmodule
